// File: rtl/alsu_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : alsu_driver_if
// Purpose  : Command, ALSU pin and response bundle between sequencer, driver
//            and ALSU datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface alsu_driver_if #(
    parameter int TAG_W = 4
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [TAG_W-1:0] cmd_tag;
    logic [2:0]       cmd_A;
    logic [2:0]       cmd_B;
    logic [2:0]       cmd_opcode;
    logic             cmd_cin;
    logic             cmd_serial_in;
    logic             cmd_direction;
    logic             cmd_red_op_A;
    logic             cmd_red_op_B;
    logic             cmd_bypass_A;
    logic             cmd_bypass_B;

    logic [2:0]       alsu_A;
    logic [2:0]       alsu_B;
    logic [2:0]       alsu_opcode;
    logic             alsu_cin;
    logic             alsu_serial_in;
    logic             alsu_direction;
    logic             alsu_red_op_A;
    logic             alsu_red_op_B;
    logic             alsu_bypass_A;
    logic             alsu_bypass_B;
    logic [5:0]       alsu_out;
    logic [15:0]      alsu_leds;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [TAG_W-1:0] rsp_tag;
    logic [5:0]       rsp_out;
    logic [15:0]      rsp_leds;
    logic             rsp_invalid;
    logic             busy;

    // Driver side
    modport slave (
        input  cmd_valid, cmd_tag, cmd_A, cmd_B, cmd_opcode, cmd_cin,
               cmd_serial_in, cmd_direction, cmd_red_op_A, cmd_red_op_B,
               cmd_bypass_A, cmd_bypass_B,
        output cmd_ready,
        output alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
               alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A,
               alsu_bypass_B,
        input  alsu_out, alsu_leds,
        output rsp_valid, rsp_tag, rsp_out, rsp_leds, rsp_invalid, busy,
        input  rsp_ready
    );

    // Sequencer / ALSU side
    modport master (
        output cmd_valid, cmd_tag, cmd_A, cmd_B, cmd_opcode, cmd_cin,
               cmd_serial_in, cmd_direction, cmd_red_op_A, cmd_red_op_B,
               cmd_bypass_A, cmd_bypass_B,
        input  cmd_ready,
        input  alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
               alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A,
               alsu_bypass_B,
        output alsu_out, alsu_leds,
        input  rsp_valid, rsp_tag, rsp_out, rsp_leds, rsp_invalid, busy,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alsu_driver.sv
`default_nettype none
// ============================================================================
// Module   : alsu_driver
// Purpose  : Buffers ALSU commands, issues one per cycle onto the ALSU pins,
//            tracks the fixed pipeline and returns tagged results.
//            Optional macro ALSU_DRV_INVALID_FLAG_EN enables the invalid flag.
// Revision : 1.0 - initial release
// ============================================================================
module alsu_driver #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4,
    parameter int LATENCY   = 2
) (
    input  wire          clk,
    input  wire          rst,   // active-low, asynchronous
    alsu_driver_if.slave bus
);
    localparam int c_CMD_AW = $clog2(CMD_DEPTH);
    localparam int c_RSP_AW = $clog2(RSP_DEPTH);
    localparam logic [c_CMD_AW:0] c_CMD_ONE = {{c_CMD_AW{1'b0}}, 1'b1};
    localparam logic [c_RSP_AW:0] c_RSP_ONE = {{c_RSP_AW{1'b0}}, 1'b1};

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] opcode;
        logic       cin;
        logic       serial_in;
        logic       direction;
        logic       red_op_a;
        logic       red_op_b;
        logic       bypass_a;
        logic       bypass_b;
    } pin_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        pin_t             pin;
    } cmd_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [5:0]       out;
        logic [15:0]      leds;
        logic             inv;
    } rsp_t;

    // Bypass of a zero A operand keeps the ALSU output quiet between issues
    localparam pin_t c_IDLE_PINS = '{a: 3'd0, b: 3'd0, opcode: 3'd0, cin: 1'b0,
                                     serial_in: 1'b0, direction: 1'b0,
                                     red_op_a: 1'b0, red_op_b: 1'b0,
                                     bypass_a: 1'b1, bypass_b: 1'b0};

    cmd_t               r_cmd_mem [CMD_DEPTH];
    logic [c_CMD_AW:0]  r_cmd_wptr;
    logic [c_CMD_AW:0]  r_cmd_rptr;
    logic               r_run;
    pin_t               r_pin;
    logic [LATENCY-1:0] r_trk_vld;
    logic [LATENCY-1:0] r_trk_inv;
    logic [TAG_W-1:0]   r_trk_tag [LATENCY];
    rsp_t               r_rsp_mem [RSP_DEPTH];
    logic [c_RSP_AW:0]  r_rsp_wptr;
    logic [c_RSP_AW:0]  r_rsp_rptr;

    cmd_t               w_cmd_in;
    cmd_t               w_cmd_head;
    logic               w_cmd_empty;
    logic               w_cmd_full;
    logic               w_cmd_push;
    logic               w_issue;
    logic               w_head_inv;
    int                 w_inflight;
    logic [c_RSP_AW:0]  w_rsp_count;
    logic               w_rsp_valid;
    logic               w_rsp_push;
    logic               w_rsp_pop;
    rsp_t               w_rsp_in;
    rsp_t               w_rsp_head;

    always_comb begin
        w_cmd_in              = '0;
        w_cmd_in.tag          = bus.cmd_tag;
        w_cmd_in.pin.a        = bus.cmd_A;
        w_cmd_in.pin.b        = bus.cmd_B;
        w_cmd_in.pin.opcode   = bus.cmd_opcode;
        w_cmd_in.pin.cin      = bus.cmd_cin;
        w_cmd_in.pin.serial_in = bus.cmd_serial_in;
        w_cmd_in.pin.direction = bus.cmd_direction;
        w_cmd_in.pin.red_op_a = bus.cmd_red_op_A;
        w_cmd_in.pin.red_op_b = bus.cmd_red_op_B;
        w_cmd_in.pin.bypass_a = bus.cmd_bypass_A;
        w_cmd_in.pin.bypass_b = bus.cmd_bypass_B;
    end

    assign w_cmd_empty = (r_cmd_wptr == r_cmd_rptr);
    assign w_cmd_full  = (r_cmd_wptr[c_CMD_AW] != r_cmd_rptr[c_CMD_AW]) &&
                         (r_cmd_wptr[c_CMD_AW-1:0] == r_cmd_rptr[c_CMD_AW-1:0]);
    assign w_cmd_push  = bus.cmd_valid & bus.cmd_ready;
    assign w_cmd_head  = r_cmd_mem[r_cmd_rptr[c_CMD_AW-1:0]];

`ifdef ALSU_DRV_INVALID_FLAG_EN
    assign w_head_inv = ~(w_cmd_head.pin.bypass_a | w_cmd_head.pin.bypass_b) &
                        (((w_cmd_head.pin.red_op_a | w_cmd_head.pin.red_op_b) &
                          (w_cmd_head.pin.opcode[1] | w_cmd_head.pin.opcode[2])) |
                         (w_cmd_head.pin.opcode[1] & w_cmd_head.pin.opcode[2]));
`else
    assign w_head_inv = 1'b0;
`endif

    always_comb begin
        w_inflight = 0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + int'(r_trk_vld[i]);
        end
    end

    // Credit rule: a response slot is reserved for every command in flight
    assign w_rsp_count = r_rsp_wptr - r_rsp_rptr;
    assign w_issue     = ~w_cmd_empty &&
                         ((int'(w_rsp_count) + w_inflight) < RSP_DEPTH);

    assign w_rsp_valid = (w_rsp_count != '0);
    assign w_rsp_pop   = w_rsp_valid & bus.rsp_ready;
    assign w_rsp_push  = r_trk_vld[LATENCY-1];
    assign w_rsp_in    = '{tag: r_trk_tag[LATENCY-1], out: bus.alsu_out,
                           leds: bus.alsu_leds, inv: r_trk_inv[LATENCY-1]};
    assign w_rsp_head  = w_rsp_valid ? r_rsp_mem[r_rsp_rptr[c_RSP_AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run      <= 1'b0;
            r_cmd_wptr <= '0;
            r_cmd_rptr <= '0;
            r_pin      <= '0;
            r_trk_vld  <= '0;
            r_trk_inv  <= '0;
            r_rsp_wptr <= '0;
            r_rsp_rptr <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_trk_tag[i] <= '0;
            end
        end else begin
            r_run <= 1'b1;
            if (w_cmd_push) r_cmd_wptr <= r_cmd_wptr + c_CMD_ONE;
            if (w_issue)    r_cmd_rptr <= r_cmd_rptr + c_CMD_ONE;
            r_pin        <= w_issue ? w_cmd_head.pin : c_IDLE_PINS;
            r_trk_vld[0] <= w_issue;
            r_trk_inv[0] <= w_issue & w_head_inv;
            r_trk_tag[0] <= w_cmd_head.tag;
            for (int i = 1; i < LATENCY; i++) begin
                r_trk_vld[i] <= r_trk_vld[i-1];
                r_trk_inv[i] <= r_trk_inv[i-1];
                r_trk_tag[i] <= r_trk_tag[i-1];
            end
            if (w_rsp_push) r_rsp_wptr <= r_rsp_wptr + c_RSP_ONE;
            if (w_rsp_pop)  r_rsp_rptr <= r_rsp_rptr + c_RSP_ONE;
        end
    end

    // Storage arrays carry no reset; pointers alone define their contents
    always_ff @(posedge clk) begin
        if (w_cmd_push) r_cmd_mem[r_cmd_wptr[c_CMD_AW-1:0]] <= w_cmd_in;
        if (w_rsp_push) r_rsp_mem[r_rsp_wptr[c_RSP_AW-1:0]] <= w_rsp_in;
    end

    assign bus.cmd_ready      = r_run & ~w_cmd_full;
    assign bus.alsu_A         = r_pin.a;
    assign bus.alsu_B         = r_pin.b;
    assign bus.alsu_opcode    = r_pin.opcode;
    assign bus.alsu_cin       = r_pin.cin;
    assign bus.alsu_serial_in = r_pin.serial_in;
    assign bus.alsu_direction = r_pin.direction;
    assign bus.alsu_red_op_A  = r_pin.red_op_a;
    assign bus.alsu_red_op_B  = r_pin.red_op_b;
    assign bus.alsu_bypass_A  = r_pin.bypass_a;
    assign bus.alsu_bypass_B  = r_pin.bypass_b;
    assign bus.rsp_valid      = w_rsp_valid;
    assign bus.rsp_tag        = w_rsp_head.tag;
    assign bus.rsp_out        = w_rsp_head.out;
    assign bus.rsp_leds       = w_rsp_head.leds;
    assign bus.rsp_invalid    = w_rsp_head.inv;
    assign bus.busy           = ~w_cmd_empty | (|r_trk_vld) | w_rsp_valid;
endmodule
`default_nettype wire
